// File: rtl/ad9866_spi_pkg.sv
// Shared definitions for the AD9866 SPI responder: frame layout, register
// addresses, power-on register defaults and the frame state encoding.
package ad9866_spi_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int INSTR_BITS     = 8;
  localparam int FRAME_RW_BIT   = 15;
  localparam int FRAME_ADDR_MSB = 12;
  localparam int FRAME_ADDR_LSB = 8;
  localparam int FRAME_DATA_MSB = 7;
  localparam int FRAME_DATA_LSB = 0;

  // Positions of the instruction fields inside the first received byte.
  localparam int INSTR_RW_POS   = FRAME_RW_BIT - INSTR_BITS;
  localparam int INSTR_ADDR_MSB = FRAME_ADDR_MSB - INSTR_BITS;
  localparam int INSTR_ADDR_LSB = FRAME_ADDR_LSB - INSTR_BITS;

  localparam logic [4:0] CNT_INSTR_LAST = 5'(INSTR_BITS - 1);
  localparam logic [4:0] CNT_FRAME_LAST = 5'(FRAME_BITS - 1);

  localparam logic [4:0] ADDR_RXGAIN = 5'h09;
  localparam logic [4:0] ADDR_TXGAIN = 5'h0a;

  localparam int NUM_REGS = 32;

  localparam logic [7:0] REG_DEFAULTS [NUM_REGS] = '{
    8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h54, 8'h30,
    8'h4B, 8'h00, 8'h00, 8'h00, 8'h43, 8'h03, 8'h81, 8'h00,
    8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WR,
    RD,
    DONE
  } state_t;

endpackage

// File: rtl/ad9866_spi_sync.sv
// Two-flop synchronizer for an asynchronous SPI line, followed by one more
// flop so single-cycle rise/fall strobes can be produced in the clk domain.
module ad9866_spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ad9866_spi_responder.sv
// SPI responder emulating the AD9866 control port: decodes 16-bit frames into
// a 32x8 register file, answers reads on sdo and exposes the gain fields.
module ad9866_spi_responder
  import ad9866_spi_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_sclk,
  input  logic       i_spi_sen_n,
  input  logic       i_spi_sdio,
  output logic       o_spi_sdo,
  output logic       o_spi_sdo_oe,
  output logic       o_wr_stb,
  output logic [4:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic [5:0] o_rx_gain,
  output logic [3:0] o_tx_gain
);

  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_sen_rise;
  logic       w_sen_fall;
  logic [1:0] r_sdio_sync;
  logic       w_sdio;

  state_t     r_state;
  logic [4:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [4:0] r_addr;
  logic [7:0] r_rd_shift;
  logic       r_sdo;
  logic       r_sdo_oe;
  logic       r_wr_stb;
  logic [4:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_frame_err;
  logic       r_busy;
  logic [7:0] r_regs [NUM_REGS];

  logic [7:0] w_byte;
  logic       w_last_rise;
  logic       w_commit;
  logic       w_in_frame;

  // sen_n syncs reset low so a line already held low at release cannot look
  // like a fresh frame start; it must first be seen high.
  ad9866_spi_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_spi_sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  ad9866_spi_sync #(.RESET_VAL(1'b0)) u_sen_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_spi_sen_n),
    .o_rise  (w_sen_rise),
    .o_fall  (w_sen_fall)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sdio_sync <= 2'b00;
    end else begin
      r_sdio_sync <= {r_sdio_sync[0], i_spi_sdio};
    end
  end

  assign w_sdio      = r_sdio_sync[1];
  assign w_byte      = {r_shift, w_sdio};
  assign w_last_rise = w_sclk_rise && (r_bit_cnt == CNT_FRAME_LAST) &&
                       ((r_state == WR) || (r_state == RD));
  assign w_commit    = w_last_rise && (r_state == WR);
  assign w_in_frame  = (r_state == INSTR) || (r_state == WR) || (r_state == RD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 5'd0;
      r_shift     <= 7'd0;
      r_addr      <= 5'd0;
      r_rd_shift  <= 8'd0;
      r_sdo       <= 1'b0;
      r_sdo_oe    <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= 5'd0;
      r_wr_data   <= 8'd0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_stb    <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_sen_fall) begin
            r_state   <= INSTR;
            r_bit_cnt <= 5'd0;
            r_busy    <= 1'b1;
          end
        end

        INSTR: begin
          if (w_sclk_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == CNT_INSTR_LAST) begin
              r_addr <= w_byte[INSTR_ADDR_MSB:INSTR_ADDR_LSB];
              if (w_byte[INSTR_RW_POS]) begin
                r_state    <= RD;
                r_rd_shift <= r_regs[w_byte[INSTR_ADDR_MSB:INSTR_ADDR_LSB]];
              end else begin
                r_state <= WR;
              end
            end
          end
        end

        WR: begin
          if (w_sclk_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == CNT_FRAME_LAST) begin
              r_wr_stb  <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_byte;
              r_state   <= DONE;
            end
          end
        end

        // Read data moves on sclk falls so it is stable at the next rise.
        RD: begin
          if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == CNT_FRAME_LAST) begin
              r_state  <= DONE;
              r_sdo    <= 1'b0;
              r_sdo_oe <= 1'b0;
            end
          end else if (w_sclk_fall) begin
            r_sdo      <= r_rd_shift[7];
            r_rd_shift <= {r_rd_shift[6:0], 1'b0};
            r_sdo_oe   <= 1'b1;
          end
        end

        DONE: begin
        end

        default: r_state <= IDLE;
      endcase

      // Placed last so an sclk rise in the same cycle is handled first.
      if (w_sen_rise) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_sdo       <= 1'b0;
        r_sdo_oe    <= 1'b0;
        r_frame_err <= w_in_frame && !w_last_rise;
      end
    end
  end

  // Flop-based so reset can load the codec's power-on defaults.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= REG_DEFAULTS[i];
      end
    end else if (w_commit) begin
      r_regs[r_addr] <= w_byte;
    end
  end

  assign o_spi_sdo    = r_sdo;
  assign o_spi_sdo_oe = r_sdo_oe;
  assign o_wr_stb     = r_wr_stb;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;
  assign o_rx_gain    = r_regs[ADDR_RXGAIN][5:0];
  assign o_tx_gain    = r_regs[ADDR_TXGAIN][3:0];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Self-checking bench for ad9866_spi_responder: table of SPI frames plus
// hand-built sequences for reset mid-frame and simultaneous sclk/sen_n rise.
module tb_ad9866_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       senN;
  logic       sdio;
  logic       sdo;
  logic       sdoOe;
  logic       wrStb;
  logic [4:0] wrAddr;
  logic [7:0] wrData;
  logic       frameErr;
  logic       busy;
  logic [5:0] rxGain;
  logic [3:0] txGain;

  always #5 clk = ~clk;

  ad9866_spi_responder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_spi_sclk   (sclk),
    .i_spi_sen_n  (senN),
    .i_spi_sdio   (sdio),
    .o_spi_sdo    (sdo),
    .o_spi_sdo_oe (sdoOe),
    .o_wr_stb     (wrStb),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .o_frame_err  (frameErr),
    .o_busy       (busy),
    .o_rx_gain    (rxGain),
    .o_tx_gain    (txGain)
  );

  typedef struct {
    logic [15:0] frame;
    int          nBits;
    int          half;
    bit          isRead;
    logic [7:0]  expRead;
    bit          expWrite;
    bit          expErr;
    string       name;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          stbCount = 0;
  int          errCount = 0;
  logic [12:0] expQ [$];
  logic [7:0]  model [32];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadModelDefaults();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    model[5'h00] = 8'h80; model[5'h06] = 8'h54; model[5'h07] = 8'h30;
    model[5'h08] = 8'h4B; model[5'h0C] = 8'h43; model[5'h0D] = 8'h03;
    model[5'h0E] = 8'h81; model[5'h10] = 8'h80;
  endtask

  // Scoreboard: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wrStb === 1'b1) begin
        stbCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected no write",
                   wrAddr, wrData);
        end else begin
          logic [12:0] exp;
          exp = expQ.pop_front();
          checkOutput("wrAddr", 32'(wrAddr), 32'(exp[12:8]));
          checkOutput("wrData", 32'(wrData), 32'(exp[7:0]));
        end
      end
      if (frameErr === 1'b1) errCount++;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clockBits(input logic [15:0] frame, input int nBits, input int half,
                           input bit isRead, output logic [7:0] rdData);
    rdData = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      sdio = (i < 16) ? frame[15 - i] : 1'b1;
      waitClk(half);
      if (isRead && i >= 8 && i < 16) begin
        rdData = {rdData[6:0], sdo};
        checkOutput($sformatf("sdoOe.bit%0d", i), 32'(sdoOe), 32'd1);
      end
      sclk = 1'b1;
      waitClk(half);
      sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v, output logic [7:0] rd);
    stbCount = 0;
    errCount = 0;
    if (v.expWrite) begin
      expQ.push_back(v.frame[12:0]);
      model[v.frame[12:8]] = v.frame[7:0];
    end
    senN = 1'b0;
    waitClk(v.half);
    clockBits(v.frame, v.nBits, v.half, v.isRead, rd);
    checkOutput({v.name, ".busyInFrame"}, 32'(busy), 32'd1);
    waitClk(v.half);
    senN = 1'b1;
    waitClk(6);
  endtask

  task automatic runVector(input vec_t v);
    logic [7:0] rd;
    applyStimulus(v, rd);
    if (v.isRead) checkOutput({v.name, ".readData"}, 32'(rd), 32'(v.expRead));
    checkOutput({v.name, ".wrStbCount"}, stbCount, v.expWrite ? 1 : 0);
    checkOutput({v.name, ".frameErrCount"}, errCount, v.expErr ? 1 : 0);
    checkOutput({v.name, ".busyAfter"}, 32'(busy), 32'd0);
    checkOutput({v.name, ".sdoOeAfter"}, 32'(sdoOe), 32'd0);
    checkOutput({v.name, ".rxGain"}, 32'(rxGain), 32'(model[5'h09][5:0]));
    checkOutput({v.name, ".txGain"}, 32'(txGain), 32'(model[5'h0A][3:0]));
    checkOutput({v.name, ".queueEmpty"}, expQ.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs [11];
    vec_t       postReset [3];
    logic [7:0] rd;

    vecs[0]  = '{16'h8600, 16, 4, 1'b1, 8'h54, 1'b0, 1'b0, "rdDefault06"};
    vecs[1]  = '{16'h8C00, 16, 4, 1'b1, 8'h43, 1'b0, 1'b0, "rdDefault0C"};
    vecs[2]  = '{16'h9500, 16, 4, 1'b1, 8'h00, 1'b0, 1'b0, "rdDefault15"};
    vecs[3]  = '{16'h0A05, 16, 2, 1'b0, 8'h00, 1'b1, 1'b0, "wrTxGain"};
    vecs[4]  = '{16'h8A00, 16, 4, 1'b1, 8'h05, 1'b0, 1'b0, "rdBack0A"};
    vecs[5]  = '{16'h097F, 16, 2, 1'b0, 8'h00, 1'b1, 1'b0, "wrRxGain"};
    vecs[6]  = '{16'h0B22, 12, 2, 1'b0, 8'h00, 1'b0, 1'b1, "truncated"};
    vecs[7]  = '{16'h8B00, 16, 4, 1'b1, 8'h00, 1'b0, 1'b0, "rdAfterTrunc"};
    vecs[8]  = '{16'h1AA5, 20, 2, 1'b0, 8'h00, 1'b1, 1'b0, "overLong"};
    vecs[9]  = '{16'h9A00, 16, 4, 1'b1, 8'hA5, 1'b0, 1'b0, "rdBack1A"};
    vecs[10] = '{16'h8000, 16, 4, 1'b1, 8'h80, 1'b0, 1'b0, "rdDefault00"};

    postReset[0] = '{16'h1466, 16, 2, 1'b0, 8'h00, 1'b1, 1'b0, "cleanWrite"};
    postReset[1] = '{16'h9400, 16, 4, 1'b1, 8'h66, 1'b0, 1'b0, "rdBack14"};
    postReset[2] = '{16'h8600, 16, 4, 1'b1, 8'h54, 1'b0, 1'b0, "rdAfterReset06"};

    loadModelDefaults();
    rst  = 1'b1;
    sclk = 1'b0;
    senN = 1'b1;
    sdio = 1'b0;
    waitClk(5);
    rst = 1'b0;
    waitClk(5);

    checkOutput("reset.sdo", 32'(sdo), 32'd0);
    checkOutput("reset.sdoOe", 32'(sdoOe), 32'd0);
    checkOutput("reset.wrStb", 32'(wrStb), 32'd0);
    checkOutput("reset.frameErr", 32'(frameErr), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.wrAddr", 32'(wrAddr), 32'd0);
    checkOutput("reset.wrData", 32'(wrData), 32'd0);
    checkOutput("reset.rxGain", 32'(rxGain), 32'd0);
    checkOutput("reset.txGain", 32'(txGain), 32'd0);

    for (int i = 0; i < 11; i++) runVector(vecs[i]);

    // 16th sclk rise and sen_n rise land together: the write still commits.
    stbCount = 0;
    errCount = 0;
    expQ.push_back(13'h1677);
    model[5'h16] = 8'h77;
    senN = 1'b0;
    waitClk(2);
    clockBits(16'h1677, 15, 2, 1'b0, rd);
    sdio = 1'b1;
    waitClk(2);
    sclk = 1'b1;
    senN = 1'b1;
    waitClk(2);
    sclk = 1'b0;
    waitClk(6);
    checkOutput("sameEdge.wrStbCount", stbCount, 1);
    checkOutput("sameEdge.frameErrCount", errCount, 0);
    checkOutput("sameEdge.busy", 32'(busy), 32'd0);

    // Reset after the 10th bit of a write, with sen_n left low afterwards.
    stbCount = 0;
    errCount = 0;
    senN = 1'b0;
    waitClk(2);
    clockBits(16'h1455, 10, 2, 1'b0, rd);
    rst = 1'b1;
    waitClk(3);
    rst = 1'b0;
    waitClk(4);
    loadModelDefaults();
    checkOutput("midReset.rxGain", 32'(rxGain), 32'(model[5'h09][5:0]));
    checkOutput("midReset.txGain", 32'(txGain), 32'(model[5'h0A][3:0]));
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    clockBits(16'h1455, 16, 2, 1'b0, rd);
    waitClk(6);
    checkOutput("midReset.noWrite", stbCount, 0);
    checkOutput("midReset.busyStuckLow", 32'(busy), 32'd0);
    senN = 1'b1;
    waitClk(6);
    checkOutput("midReset.frameErrCount", errCount, 0);

    for (int i = 0; i < 3; i++) runVector(postReset[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad9866_spi_responder.md
# ad9866_spi_responder

Synthesizable SPI responder for the AD9866 3-/4-wire configuration bus: the far end of the write-capable SPI initiator in the AD9866 front-end block. It oversamples sclk/sen_n/sdio on the system clock, decodes 16-bit frames into a 32×8 register file, and answers reads on sdo. It is used for loopback on the bench and in companion-board images that emulate the codec's control plane. It exposes decoded gain fields and a write strobe to downstream logic.

## Interface
- SCLK_MIN_HALF, 4: minimum sclk half-period in clk cycles the block guarantees to track; reads require ≥ 4.
- clk  input  1  system clock, the same domain as the initiator.
- rst  input  1  reset, asynchronous active-high.
- spi_sclk  input  1  serial clock from initiator, asynchronous to clk; idles low.
- spi_sen_n  input  1  active-low frame enable.
- spi_sdio  input  1  serial data in; sampled on sclk rising.
- spi_sdo  output  1  serial read data; MSB first.
- spi_sdo_oe  output  1  high while read data is driven.
- wr_stb  output  1  one-cycle pulse on committed write.
- wr_addr  output  5  address of the last commit; held.
- wr_data  output  8  data of the last commit; held.
- frame_err  output  1  one-cycle pulse on a truncated frame.
- busy  output  1  high from the detected sen_n fall to the detected sen_n rise.
- rx_gain  output  6  reg[0x09][5:0].
- tx_gain  output  4  reg[0x0a][3:0].

## Operation
- Synchronizers: each input goes through a 2-flop synchronizer, then a third flop for edge detection. All decode uses the synchronized signals.
- Frame format, MSB first: bit15 R/W (1 = read); bits14:13 width, ignored and treated as single byte; bits12:8 address; bits7:0 data.
- State machine:
  - IDLE → INSTR on a detected sen_n fall. The bit counter is cleared.
  - INSTR: each detected sclk rise shifts in sdio. At the 8th rise, latch rw and addr, then go to WR or RD.
  - WR: shift 8 data bits. On the 16th rise, write reg[addr] <= data, pulse wr_stb and update wr_addr/wr_data, then go to DONE.
  - RD: load a shifter from reg[addr] at the 8th rise. On each of the next 8 detected sclk falls, drive spi_sdo from the shifter MSB and assert spi_sdo_oe. After the 16th rise, go to DONE.
  - DONE: extra sclk edges are ignored; spi_sdo_oe is 0.
  - Any state → IDLE on a detected sen_n rise.
- A sen_n rise in INSTR/WR/RD before the 16th rise pulses frame_err. The register file is unchanged.
- A sclk rise and a sen_n rise detected in the same clk: the rise is processed first. A 16th-bit write still commits and frame_err stays 0.
- Reset values:
  - registers take the defaults from the package table: 0x00=0x80, 0x06=0x54, 0x07=0x30, 0x08=0x4B, 0x0C=0x43, 0x0D=0x03, 0x0E=0x81, 0x10=0x80, all others 0x00.
  - state IDLE; spi_sdo, spi_sdo_oe, wr_stb, frame_err and busy are 0; wr_addr and wr_data are 0.
- Reset mid-frame: the frame is discarded. After reset release, no frame starts until a synchronized sen_n high followed by a fall is seen.
- Reads never modify registers. Addresses 0x14–0x1F are writable and readable scratch locations.

## Timing
- Input-to-decode latency: a raw edge first sampled at clk edge e0 is detected between e1 and e2. Registered effects are visible after e2, i.e. 3 clk edges including the sampling edge.
- wr_stb is high for exactly one cycle, 3 clk after the raw 16th sclk rise is sampled. rx_gain and tx_gain update on that same cycle.
- spi_sdo changes 3 clk after the raw sclk fall, so the initiator must hold sclk low for ≥ 4 clk on reads.
- Writes track sclk half-periods of ≥ 2 clk, which is the initiator's rate.
- busy rises 3 clk after the raw sen_n fall and falls 3 clk after the raw sen_n rise.

## Structure
- Package ad9866_spi_pkg holds:
  - register address localparams (ADDR_RXGAIN=5'h09, ADDR_TXGAIN=5'h0a);
  - the 32-entry default table;
  - the state enum {IDLE, INSTR, WR, RD, DONE};
  - the frame field bit positions.
- Sub-module ad9866_spi_sync (2-flop synchronizer plus edge-detect flop, with rise/fall outputs) is instantiated for sclk and sen_n. sdio uses the 2-flop path only.
- The register file is flops, not inferred RAM, so the async reset loads the defaults.

## Test plan
- Reset defaults: assert rst, release, then read addr 0x06 → spi_sdo shifts 0x54. Likewise 0x0C → 0x43 and 0x15 → 0x00.
- Initiator-rate write: frame 16'h0A05 with 2-clk sclk half-period → wr_stb one cycle, wr_addr=0x0A, wr_data=0x05, tx_gain=4'h5. Read back 0x0A → 0x05.
- RX gain write: frame 16'h097F → rx_gain=6'h3F, frame_err=0, busy low after sen_n rise.
- Truncated frame: sen_n rises after 12 bits of 16'h0B22 → frame_err pulse, no wr_stb, reg 0x0B still 0x00.
- Over-long frame: 20 sclk pulses carrying 16'h1AA5 then 4 extra bits → single write of 0xA5 to 0x1A, extra bits ignored.
- Reset mid-frame: assert rst after the 10th bit of a write → defaults restored. A subsequent sclk burst with sen_n still low produces no write. A clean next frame works.
